// File: rtl/demux_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : demux_scan_driver                                            |
// | Description : Serialises a 4-bit word onto the F/sel inputs of a 1-to-4    |
// |               demux. Each channel is held for HOLD_CYCLES cycles; words    |
// |               arrive over a valid/ready handshake and may stream           |
// |               back-to-back with no idle bubble between frames.             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk        in   1  rising-edge clock                                      |
// |   rst        in   1  synchronous, active-high reset                         |
// |   in_data    in   4  word to scan; bit i is routed to demux channel i       |
// |   in_valid   in   1  in_data is valid this cycle                            |
// |   in_ready   out  1  word is accepted on this edge when in_valid is high    |
// |   F          out  1  serial data bit to demux F                             |
// |   sel        out  2  channel select to demux sel                            |
// |   busy       out  1  high while a frame is being scanned                    |
// |   frame_done out  1  pulse during the final cycle of the last channel       |
// +----------------------------------------------------------------------------+
// | Build option                                                               |
// |   DEMUX_SCAN_MSB_FIRST_EN : scan channels 3,2,1,0 instead of 0,1,2,3;      |
// |                             idle/reset sel becomes 2'b11.                  |
// +----------------------------------------------------------------------------+
module demux_scan_driver #(
    parameter int HOLD_CYCLES = 1,   // cycles each channel is held, 1..16
    parameter int CNT_W       = 4    // hold counter width, 2^CNT_W >= HOLD_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       F,
    output logic [1:0] sel,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_SCAN = 1'b1;

`ifdef DEMUX_SCAN_MSB_FIRST_EN
    localparam logic [1:0] c_SEL_FIRST = 2'b11;
    localparam logic [1:0] c_SEL_LAST  = 2'b00;
`else
    localparam logic [1:0] c_SEL_FIRST = 2'b00;
    localparam logic [1:0] c_SEL_LAST  = 2'b11;
`endif

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    // State and datapath registers
    logic [0:0]       r_state;
    logic [1:0]       r_sel;
    logic             r_f;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_word;

    // Next-state values
    logic [0:0]       w_state_nxt;
    logic [1:0]       w_sel_nxt;
    logic             w_f_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_word_nxt;

    logic [1:0]       w_sel_step;
    logic             w_hold_end;
    logic             w_frame_last;
    logic             w_ready;
    logic             w_accept;

    // Channel that follows the current one in scan order.
`ifdef DEMUX_SCAN_MSB_FIRST_EN
    assign w_sel_step = r_sel - 2'd1;
`else
    assign w_sel_step = r_sel + 2'd1;
`endif

    // Everything below is decoded purely from registers, so frame_done and
    // in_ready cannot glitch on in_valid/in_data activity.
    assign w_hold_end   = (r_cnt == c_CNT_LAST);
    assign w_frame_last = (r_state == c_ST_SCAN) && (r_sel == c_SEL_LAST) && w_hold_end;
    assign w_ready      = (r_state == c_ST_IDLE) || w_frame_last;
    assign w_accept     = in_valid && w_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_sel   <= c_SEL_FIRST;
            r_f     <= 1'b0;
            r_cnt   <= '0;
            r_word  <= 4'b0000;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_f     <= w_f_nxt;
            r_cnt   <= w_cnt_nxt;
            r_word  <= w_word_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // F and sel are always updated together so the demux never sees the
    // previous channel's bit on a newly selected channel.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_f_nxt     = r_f;
        w_cnt_nxt   = r_cnt;
        w_word_nxt  = r_word;

        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = c_ST_SCAN;
                    w_word_nxt  = in_data;
                    w_sel_nxt   = c_SEL_FIRST;
                    w_f_nxt     = in_data[c_SEL_FIRST];
                    w_cnt_nxt   = '0;
                end
            end

            c_ST_SCAN: begin
                if (!w_hold_end) begin
                    // Still dwelling on the current channel.
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end else if (r_sel != c_SEL_LAST) begin
                    // Move to the next channel; bit comes from the captured
                    // word so mid-frame in_data changes have no effect.
                    w_sel_nxt = w_sel_step;
                    w_f_nxt   = r_word[w_sel_step];
                    w_cnt_nxt = '0;
                end else if (w_accept) begin
                    // Final cycle with a word waiting: start the next frame
                    // on this very edge, no idle gap.
                    w_state_nxt = c_ST_SCAN;
                    w_word_nxt  = in_data;
                    w_sel_nxt   = c_SEL_FIRST;
                    w_f_nxt     = in_data[c_SEL_FIRST];
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = c_ST_IDLE;
                    w_sel_nxt   = c_SEL_FIRST;
                    w_f_nxt     = 1'b0;
                    w_cnt_nxt   = '0;
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
                w_sel_nxt   = c_SEL_FIRST;
                w_f_nxt     = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign F          = r_f;
    assign sel        = r_sel;
    assign busy       = (r_state == c_ST_SCAN);
    assign frame_done = w_frame_last;
    assign in_ready   = w_ready;

endmodule
`default_nettype wire
